// File: rtl/fetch_unit.sv
// fetch_unit -- single-issue instruction fetch stage.
//
// Issues a word index to a synchronous-read instruction memory (data returns
// one edge after the address) and hands fetched words to decode through a
// valid/ready pair. Under backpressure the in-flight address is re-presented,
// so the memory output stays valid for the held word and no skid buffer is
// needed. A redirect flushes the in-flight read and refetches from the target.
//
// Optional feature macro: FETCH_BOUND_CHECK_EN
//   defined   : a redirect to a target >= DEPTH raises sticky out_err and halts
//               fetch until reset.
//   undefined : the target is reduced modulo DEPTH and out_err is tied 0.
//
// Ports
//   clk          sole clock, posedge
//   rst_n        asynchronous active-low reset
//   out_addr     word index to memory (zero-extended, combinational)
//   in_instr     memory read data for the address presented last edge
//   in_redirect  branch/jump taken: flush and refetch
//   in_target    word index of redirect destination
//   out_instr    fetched instruction (registered)
//   out_pc       word index of out_instr (registered)
//   out_valid    out_instr/out_pc hold a live instruction
//   in_ready     decode accepts; transfer on out_valid && in_ready
//   out_err      sticky bad-target flag
module fetch_unit #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] out_addr,
  input  logic [31:0] in_instr,
  input  logic        in_redirect,
  input  logic [31:0] in_target,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_valid,
  input  logic        in_ready,
  output logic        out_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] pc, req_pc, out_pc_q;
  logic [AW-1:0] tgt, pc_inc, tgt_inc;
  logic          req_valid;
  logic          hold;
  logic          bad_redirect;  // redirect that must trip the error path
  logic          halt;          // fetch stopped after a bad redirect

  // Power-of-two depth: truncating to AW bits gives modulo-DEPTH wrap for free.
  assign tgt     = in_target[AW-1:0];
  assign pc_inc  = pc + AW'(1);
  assign tgt_inc = tgt + AW'(1);

  assign hold = out_valid && !in_ready && !in_redirect;

`ifdef FETCH_BOUND_CHECK_EN
  logic err_q;

  assign bad_redirect = in_redirect && (in_target >= 32'(DEPTH));
  assign halt         = err_q;
  assign out_err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            err_q <= 1'b0;
    else if (bad_redirect) err_q <= 1'b1;
  end
`else
  // Upper target bits are deliberately dropped (modulo reduction).
  logic unused_tgt_hi;
  assign unused_tgt_hi = ^in_target[31:AW];
  assign bad_redirect  = 1'b0;
  assign halt          = 1'b0;
  assign out_err       = 1'b0;
`endif

  // Held cycles re-present req_pc so the memory keeps returning the same word.
  always_comb begin
    out_addr = 32'd0;
    if (!rst_n)           out_addr = 32'd0;
    else if (in_redirect) out_addr = {{(32-AW){1'b0}}, tgt};
    else if (hold)        out_addr = {{(32-AW){1'b0}}, req_pc};
    else                  out_addr = {{(32-AW){1'b0}}, pc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      req_pc    <= '0;
      req_valid <= 1'b0;
      out_pc_q  <= '0;
      out_instr <= 32'd0;
      out_valid <= 1'b0;
    end else if (halt || bad_redirect) begin
      // Halted: nothing in flight, nothing presented, redirects ignored.
      req_valid <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_redirect) begin
      // Flush: the word in flight belongs to the wrong path.
      out_valid <= 1'b0;
      req_pc    <= tgt;
      req_valid <= 1'b1;
      pc        <= tgt_inc;
    end else if (!hold) begin
      out_valid <= req_valid;
      out_instr <= in_instr;
      out_pc_q  <= req_pc;
      req_pc    <= pc;
      req_valid <= 1'b1;
      pc        <= pc_inc;
    end
  end

  assign out_pc = {{(32-AW){1'b0}}, out_pc_q};

endmodule
